// File: rtl/ps2_frame_tx.sv
// ps2_frame_tx -- device-side PS/2-style serial frame transmitter.
//
// Accepts a word on a valid/ready handshake. It then sends the word on an
// open-collector-style clock/data pair. The frame is sent LSB-first as:
//   start(0), DATA_BITS data bits, optional odd parity, STOP_BITS stop(1).
// Each bit takes one slot of 4*QUARTER system clocks. Within a slot:
//   - ps2_dat changes a quarter period in, while ps2_clk is high.
//   - ps2_clk is low for the second half, so the host samples on the fall.
// After each frame or abort, IDLE_BITS idle bit periods are enforced.
//
// Optional feature macro: PS2_TX_PARITY_EN.
//   Defined: an odd-parity bit (XNOR-reduce of the data) follows the data.
//   Undefined: the frame has no parity slot.
//
// Parameters:
//   DATA_BITS  data bits per frame (1..16)
//   QUARTER    system clocks per quarter bit period (>=1)
//   STOP_BITS  stop bits per frame (1..2)
//   IDLE_BITS  idle bit periods after each frame or abort (>=0)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_data   word to send, captured on accept
//   in_valid  word available
//   in_ready  block can accept (IDLE and not inhibited), combinational
//   inhibit   host inhibit, already synchronised to clk
//   ps2_clk   serial clock, registered, idle high
//   ps2_dat   serial data, registered, idle high
//   busy      registered, high while sending or in the idle gap
//   done      registered, one-cycle pulse on normal frame completion
//   aborted   registered, one-cycle pulse when inhibit kills a frame

module ps2_frame_tx #(
  parameter int DATA_BITS = 8,
  parameter int QUARTER   = 2,
  parameter int STOP_BITS = 1,
  parameter int IDLE_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 inhibit,
  output logic                 ps2_clk,
  output logic                 ps2_dat,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

`ifdef PS2_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int NSLOT  = DATA_BITS + 1 + STOP_BITS + PAR_BITS;
  localparam int BITCYC = 4 * QUARTER;
  localparam int KW     = $clog2(BITCYC);
  localparam int SW     = $clog2(NSLOT);
  localparam int GAPCYC = IDLE_BITS * BITCYC;
  localparam int GW     = (GAPCYC > 1) ? $clog2(GAPCYC) : 1;

  localparam logic [KW-1:0] K_DAT  = KW'(QUARTER);
  localparam logic [KW-1:0] K_FALL = KW'(2 * QUARTER);
  localparam logic [KW-1:0] K_LAST = KW'(BITCYC - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NSLOT - 1);
  localparam logic [GW-1:0] G_LAST = GW'((GAPCYC > 0) ? GAPCYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [KW-1:0]   k, k_n;
  logic [SW-1:0]   slot, slot_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic            clk_n, dat_n, busy_n, done_n, abort_n;
  logic            load;
  logic [NSLOT-1:0] frame_d, frame;

  // The whole frame is assembled at accept time. slot i then simply sends
  // frame[i], and in_data is free to change during the frame.
`ifdef PS2_TX_PARITY_EN
  assign frame_d = {{STOP_BITS{1'b1}}, ~^in_data, in_data, 1'b0};
`else
  assign frame_d = {{STOP_BITS{1'b1}}, in_data, 1'b0};
`endif

  assign in_ready = (state == IDLE) && !inhibit;

  always_comb begin
    state_n = state;
    k_n     = k;
    slot_n  = slot;
    gcnt_n  = gcnt;
    clk_n   = 1'b1;
    dat_n   = ps2_dat;
    done_n  = 1'b0;
    abort_n = 1'b0;
    load    = 1'b0;

    case (state)
      IDLE: begin
        dat_n = 1'b1;
        if (in_valid && in_ready) begin
          load    = 1'b1;
          state_n = SEND;
          k_n     = '0;
          slot_n  = '0;
        end
      end

      SEND: begin
        // The final falling edge is issued at slot N-1, k=2Q. From that
        // point the host has the whole frame, so inhibit no longer aborts.
        if (inhibit && !((slot == S_LAST) && (k >= K_FALL))) begin
          abort_n = 1'b1;
          dat_n   = 1'b1;
          gcnt_n  = '0;
          if (GAPCYC > 0) state_n = GAP;
          else            state_n = IDLE;
        end else if ((slot == S_LAST) && (k == K_LAST)) begin
          done_n = 1'b1;
          dat_n  = 1'b1;
          gcnt_n = '0;
          if (GAPCYC > 0) state_n = GAP;
          else            state_n = IDLE;
        end else begin
          if (k == K_LAST) begin
            k_n    = '0;
            slot_n = slot + 1'b1;
          end else begin
            k_n = k + 1'b1;
          end
          clk_n = !(k_n >= K_FALL);
          // Data moves only a quarter period into the slot, while the clock
          // is high. Before that it keeps the previous bit.
          if (k_n == K_DAT) dat_n = frame[slot_n];
        end
      end

      GAP: begin
        dat_n = 1'b1;
        if (gcnt == G_LAST) state_n = IDLE;
        else                gcnt_n  = gcnt + 1'b1;
      end

      default: begin
        state_n = IDLE;
        dat_n   = 1'b1;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      slot    <= '0;
      gcnt    <= '0;
      ps2_clk <= 1'b1;
      ps2_dat <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_n;
      k       <= k_n;
      slot    <= slot_n;
      gcnt    <= gcnt_n;
      ps2_clk <= clk_n;
      ps2_dat <= dat_n;
      busy    <= busy_n;
      done    <= done_n;
      aborted <= abort_n;
    end
  end

  // Frame contents are datapath only. They are meaningful only after load,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (load) frame <= frame_d;
  end

endmodule

// File: tb/tb_ps2_frame_tx.sv
module tb_ps2_frame_tx;

`ifdef PS2_TX_PARITY_EN
  localparam int NS  = 11;
  localparam int CNS = 9;
`else
  localparam int NS  = 10;
  localparam int CNS = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_ready, inhibit;
  logic       ps2_clk, ps2_dat, busy, done, aborted;

  logic [4:0] c_in_data;
  logic       c_in_valid, c_in_ready, c_inhibit;
  logic       c_ps2_clk, c_ps2_dat, c_busy, c_done, c_aborted;

  int total = 0;
  int bad   = 0;

  ps2_frame_tx u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .inhibit(inhibit), .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat), .busy(busy), .done(done), .aborted(aborted)
  );

  ps2_frame_tx #(.DATA_BITS(5), .QUARTER(3), .STOP_BITS(2), .IDLE_BITS(0)) u_cfg (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .inhibit(c_inhibit), .ps2_clk(c_ps2_clk),
    .ps2_dat(c_ps2_dat), .busy(c_busy), .done(c_done), .aborted(c_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_bits(input logic [7:0] d);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
`ifdef PS2_TX_PARITY_EN
    b[9]  = ~^d;
    b[10] = 1'b1;
`else
    b[9]  = 1'b1;
`endif
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_and_check(input logic [7:0] d, input logic [15:0] exp_bits,
                                input string tag);
    logic [15:0] got;
    int nf, ndone, nabort, done_cyc, first_fall;
    logic prev;
    got = '0; nf = 0; ndone = 0; nabort = 0; done_cyc = -1; first_fall = -1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_pre got=%b exp=1", tag, in_ready);
    end
    in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = ~d;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin
      bad++;
      $display("FAIL %s accept busy=%b rdy=%b clk=%b dat=%b exp 1 0 1 1",
               tag, busy, in_ready, ps2_clk, ps2_dat);
    end
    prev = ps2_clk;
    for (int c = 1; c <= NS*8 + 8; c++) begin
      step();
      if (prev === 1'b1 && ps2_clk === 1'b0) begin
        if (nf < 16) got[nf] = ps2_dat;
        if (first_fall < 0) first_fall = c;
        nf++;
      end
      prev = ps2_clk;
      if (c == 2) begin
        total++;
        if (ps2_dat !== 1'b0) begin
          bad++; $display("FAIL %s start_dat got=%b exp=0", tag, ps2_dat);
        end
      end
      if (done === 1'b1) begin ndone++; done_cyc = c; end
      if (aborted !== 1'b0) nabort++;
      if (c == NS*8 + 7) begin
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL %s gap_end rdy=%b busy=%b exp 0 1", tag, in_ready, busy);
        end
      end
    end
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s idle rdy=%b busy=%b exp 1 0", tag, in_ready, busy);
    end
    total++;
    if (first_fall != 4) begin
      bad++; $display("FAIL %s first_fall got=%0d exp=4", tag, first_fall);
    end
    total++;
    if (nf != NS || got !== exp_bits) begin
      bad++; $display("FAIL %s bits got=%h/%0d exp=%h/%0d", tag, got, nf, exp_bits, NS);
    end
    total++;
    if (ndone != 1 || done_cyc != NS*8 || nabort != 0) begin
      bad++;
      $display("FAIL %s done n=%0d cyc=%0d abort=%0d exp 1 %0d 0",
               tag, ndone, done_cyc, nabort, NS*8);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inhibit = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    c_in_valid = 1'b0; c_in_data = 5'h00; c_inhibit = 1'b0;
    step(); step();
    total++;
    if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || aborted !== 1'b0) begin
      bad++;
      $display("FAIL reset_state clk=%b dat=%b busy=%b done=%b ab=%b exp 1 1 0 0 0",
               ps2_clk, ps2_dat, busy, done, aborted);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", in_ready); end
    inhibit = 1'b1; #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy_inh got=%b exp=0", in_ready); end
    inhibit = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || ps2_clk !== 1'b1) begin
      bad++; $display("FAIL post_reset rdy=%b busy=%b clk=%b exp 1 0 1", in_ready, busy, ps2_clk);
    end
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 16; v++) begin
      logic [7:0] d;
      d = 8'(v);
      send_and_check(d, model_bits(d), $sformatf("b2b_%0d", v));
    end
  endtask

  task automatic test_parity();
`ifdef PS2_TX_PARITY_EN
    send_and_check(8'h01, 16'h0402, "par_01");
    send_and_check(8'h00, 16'h0600, "par_00");
`else
    send_and_check(8'h01, 16'h0202, "nopar_01");
    send_and_check(8'h00, 16'h0200, "nopar_00");
`endif
  endtask

  task automatic test_abort();
    int nd;
    nd = 0;
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 30; c++) step();
    total++;
    if (ps2_clk !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_pre clk=%b busy=%b exp 0 1", ps2_clk, busy);
    end
    inhibit = 1'b1;
    step();
    inhibit = 1'b0;
    total++;
    if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1 || aborted !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_pulse clk=%b dat=%b ab=%b done=%b exp 1 1 1 0",
               ps2_clk, ps2_dat, aborted, done);
    end
    for (int c = 32; c <= 38; c++) begin
      step();
      if (done !== 1'b0 || aborted !== 1'b0 || in_ready !== 1'b0) nd++;
    end
    total++;
    if (nd != 0) begin bad++; $display("FAIL abort_gap bad_cycles got=%0d exp=0", nd); end
    step();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle rdy=%b busy=%b done=%b exp 1 0 0", in_ready, busy, done);
    end
    inhibit = 1'b1; in_valid = 1'b1; nd = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (in_ready !== 1'b0 || busy !== 1'b0 || ps2_clk !== 1'b1) nd++;
    end
    total++;
    if (nd != 0) begin bad++; $display("FAIL inhibit_idle bad_cycles got=%0d exp=0", nd); end
    in_valid = 1'b0; inhibit = 1'b0;
    step();
  endtask

  task automatic test_stop_inhibit();
    int ndone, nab, done_cyc;
    ndone = 0; nab = 0; done_cyc = -1;
    in_data = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= NS*8 + 8; c++) begin
      step();
      if (c == (NS-1)*8 + 4) inhibit = 1'b1;
      if (done === 1'b1) begin ndone++; done_cyc = c; end
      if (aborted !== 1'b0) nab++;
      if (c == NS*8) inhibit = 1'b0;
    end
    total++;
    if (ndone != 1 || done_cyc != NS*8 || nab != 0) begin
      bad++;
      $display("FAIL stop_inhibit done n=%0d cyc=%0d ab=%0d exp 1 %0d 0",
               ndone, done_cyc, nab, NS*8);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL stop_inhibit_rdy got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int np;
    np = 0;
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) step();
    total++;
    if (ps2_clk !== 1'b0) begin bad++; $display("FAIL rmid_pre clk got=%b exp=0", ps2_clk); end
    rst_n = 1'b0;
    #1;
    total++;
    if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || aborted !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async clk=%b dat=%b busy=%b done=%b ab=%b exp 1 1 0 0 0",
               ps2_clk, ps2_dat, busy, done, aborted);
    end
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done !== 1'b0 || aborted !== 1'b0 || in_ready !== 1'b1 || ps2_clk !== 1'b1) np++;
    end
    total++;
    if (np != 0) begin bad++; $display("FAIL rmid_after bad_cycles got=%0d exp=0", np); end
    send_and_check(8'hA5, model_bits(8'hA5), "post_reset_a5");
  endtask

  task automatic test_config();
    logic [15:0] got, exp_bits;
    int nf, ndone, done_cyc, rdy_at_done;
    logic prev;
`ifdef PS2_TX_PARITY_EN
    exp_bits = 16'h01A6;
`else
    exp_bits = 16'h00E6;
`endif
    got = '0; nf = 0; ndone = 0; done_cyc = -1; rdy_at_done = 0;
    total++;
    if (c_in_ready !== 1'b1) begin bad++; $display("FAIL cfg_rdy_pre got=%b exp=1", c_in_ready); end
    c_in_data = 5'h13; c_in_valid = 1'b1;
    step();
    c_in_valid = 1'b0; c_in_data = 5'h0C;
    prev = c_ps2_clk;
    for (int c = 1; c <= CNS*12 + 4; c++) begin
      step();
      if (prev === 1'b1 && c_ps2_clk === 1'b0) begin
        if (nf < 16) got[nf] = c_ps2_dat;
        nf++;
      end
      prev = c_ps2_clk;
      if (c_done === 1'b1) begin
        ndone++; done_cyc = c;
        if (c_in_ready === 1'b1 && c_busy === 1'b0) rdy_at_done = 1;
      end
    end
    total++;
    if (nf != CNS || got !== exp_bits) begin
      bad++; $display("FAIL cfg_bits got=%h/%0d exp=%h/%0d", got, nf, exp_bits, CNS);
    end
    total++;
    if (ndone != 1 || done_cyc != CNS*12 || rdy_at_done != 1) begin
      bad++;
      $display("FAIL cfg_done n=%0d cyc=%0d rdy=%0d exp 1 %0d 1", ndone, done_cyc,
               rdy_at_done, CNS*12);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity();
    test_abort();
    test_stop_inhibit();
    test_reset_mid();
    test_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
